// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates at tail, completes via the CDB,
// retires from head, and squashes everything on a mispredicted branch.
module reorder_buffer #(
  parameter int DEPTH  = 8,
  parameter int TAG_W  = 3,
  parameter int DATA_W = 16,
  parameter int REG_W  = 4
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              alloc_valid,
  input  logic [REG_W-1:0]  alloc_dest,
  input  logic              alloc_is_branch,
  output logic              alloc_ready,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic              cdb_mispredict,
  output logic              commit_valid,
  output logic [REG_W-1:0]  commit_dest,
  output logic [DATA_W-1:0] commit_data,
  output logic [TAG_W-1:0]  commit_tag,
  output logic              flush,
  output logic [TAG_W:0]    count
);

  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [DEPTH-1:0]  done_q, done_d;
  logic [DEPTH-1:0]  br_q, br_d;
  logic [DEPTH-1:0]  mp_q, mp_d;
  logic [REG_W-1:0]  dest_q [DEPTH];
  logic [REG_W-1:0]  dest_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [TAG_W-1:0]  head_q, head_d;
  logic [TAG_W-1:0]  tail_q, tail_d;
  logic [TAG_W:0]    count_q, count_d;
  logic              flush_q, flush_d;

  logic flush_now;
  logic alloc_fire;
  logic cdb_hit;

  assign commit_valid = busy_q[head_q] & done_q[head_q];
  assign flush_now    = commit_valid & br_q[head_q] & mp_q[head_q];
  assign alloc_ready  = (count_q < (TAG_W+1)'(DEPTH)) & ~flush_now;
  assign alloc_fire   = alloc_valid & alloc_ready;
  assign cdb_hit      = cdb_valid & busy_q[cdb_tag] & ~done_q[cdb_tag];

  assign alloc_tag    = tail_q;
  assign commit_tag   = head_q;
  assign commit_dest  = dest_q[head_q];
  assign commit_data  = data_q[head_q];
  assign flush        = flush_q;
  assign count        = count_q;

  always_comb begin
    busy_d  = busy_q;
    done_d  = done_q;
    br_d    = br_q;
    mp_d    = mp_q;
    dest_d  = dest_q;
    data_d  = data_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    flush_d = 1'b0;
    if (flush_now) begin
      busy_d  = '0;
      done_d  = '0;
      mp_d    = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      flush_d = 1'b1;
    end else begin
      if (cdb_hit) begin
        done_d[cdb_tag] = 1'b1;
        data_d[cdb_tag] = cdb_data;
        mp_d[cdb_tag]   = br_q[cdb_tag] & cdb_mispredict;
      end
      if (commit_valid) begin
        busy_d[head_q] = 1'b0;
        head_d         = head_q + TAG_W'(1);
      end
      // tail slot is never busy when ready, so no clash with CDB/commit
      if (alloc_fire) begin
        busy_d[tail_q] = 1'b1;
        done_d[tail_q] = 1'b0;
        br_d[tail_q]   = alloc_is_branch;
        mp_d[tail_q]   = 1'b0;
        dest_d[tail_q] = alloc_dest;
        tail_d         = tail_q + TAG_W'(1);
      end
      unique case ({alloc_fire, commit_valid})
        2'b10:   count_d = count_q + (TAG_W+1)'(1);
        2'b01:   count_d = count_q - (TAG_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      busy_q  <= '0;
      done_q  <= '0;
      br_q    <= '0;
      mp_q    <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      flush_q <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      done_q  <= done_d;
      br_q    <= br_d;
      mp_q    <= mp_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      flush_q <= flush_d;
    end
  end

  always_ff @(posedge clk1) begin
    dest_q <= dest_d;
    data_q <= data_d;
  end

endmodule
